// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - eight-digit multiplexed seven-segment scanner with frame-synchronous load
//
// Scans eight common-anode digits one slot at a time. The first BLANK_CYC cycles of each slot
// keep everything dark to suppress ghosting. New display data is staged in a pending buffer
// and only becomes active at a frame boundary (idx 7 wrapping to 0), so a frame never tears.
//
// Ports:
//   Clk_50MHz  in   system clock, rising edge
//   Reset_N    in   asynchronous active-low reset
//   load       in   single-cycle request to capture digits_in/dots_in into the pending buffer
//   digits_in  in   [31:0] eight hex nibbles, nibble k drives digit k
//   dots_in    in   [7:0] bit k lights the decimal point of digit k
//   load_ack   out  one-cycle pulse when pending data becomes the active display
//   seg_out    out  [7:0] active-low segments {dp,g,f,e,d,c,b,a}
//   dig_sel    out  [7:0] active-low one-hot digit enable
module seg_scan #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        Clk_50MHz,
  input  logic        Reset_N,
  input  logic        load,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dots_in,
  output logic        load_ack,
  output logic [7:0]  seg_out,
  output logic [7:0]  dig_sel
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] slot_cnt;
  logic [2:0]    idx;
  logic          pend_flag;
  logic          valid;
  logic [31:0]   act_digits;
  logic [7:0]    act_dots;
  logic [31:0]   pend_digits;
  logic [7:0]    pend_dots;

  logic          slot_wrap;
  logic          frame_end;
  logic [3:0]    cur_nib;
  logic [7:0]    seg_nxt;
  logic [7:0]    dig_nxt;

  // Active-low g..a code for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_wrap && (idx == 3'd7);
  assign cur_nib   = act_digits[{idx, 2'b00} +: 4];

  // Scan position.
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      slot_cnt <= '0;
      idx      <= 3'd0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Pending/active double buffer. A load in the boundary cycle refills pending after the
  // old pending contents have been promoted, so it lands one frame later.
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      pend_flag   <= 1'b0;
      valid       <= 1'b0;
      act_digits  <= '0;
      act_dots    <= '0;
      pend_digits <= '0;
      pend_dots   <= '0;
      load_ack    <= 1'b0;
    end else begin
      load_ack <= frame_end && pend_flag;
      if (frame_end && pend_flag) begin
        act_digits <= pend_digits;
        act_dots   <= pend_dots;
        valid      <= 1'b1;
      end
      if (load) begin
        pend_digits <= digits_in;
        pend_dots   <= dots_in;
        pend_flag   <= 1'b1;
      end else if (frame_end) begin
        pend_flag   <= 1'b0;
      end
    end
  end

  always_comb begin
    seg_nxt = 8'hFF;
    dig_nxt = 8'hFF;
    if (valid && (slot_cnt >= BLANK_END)) begin
      dig_nxt = ~(8'd1 << idx);
      seg_nxt = {~act_dots[idx], hex7(cur_nib)};
    end
  end

  // Registered drivers: outputs trail slot_cnt/idx by one cycle.
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      seg_out <= 8'hFF;
      dig_sel <= 8'hFF;
    end else begin
      seg_out <= seg_nxt;
      dig_sel <= dig_nxt;
    end
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 50000, meaning clock cycles per digit slot; the legal range is 4..2^20.
REQ-002 SHALL provide parameter BLANK_CYC, default 500, meaning the cycles at the start of each slot with all digits off; it is legal when 1 <= BLANK_CYC < CLK_DIV.
REQ-003 SHALL provide port Clk_50MHz, input, 1 bit, the single system clock, rising edge.
REQ-004 SHALL provide port Reset_N, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL provide port load, input, 1 bit, a single-cycle request to capture new display data.
REQ-006 SHALL provide port digits_in, input, 32 bits, eight hex nibbles; nibble k ([4k+3:4k]) drives digit k.
REQ-007 SHALL provide port dots_in, input, 8 bits; bit k lights the decimal point of digit k.
REQ-008 SHALL provide port load_ack, output, 1 bit, a one-cycle pulse when pending data becomes the active display.
REQ-009 SHALL provide port seg_out, output, 8 bits, active-low segments {dp,g,f,e,d,c,b,a} from bit 7 down to bit 0.
REQ-010 SHALL provide port dig_sel, output, 8 bits, an active-low one-hot digit enable; bit k selects digit k.

Function
REQ-011 SHALL count slot_cnt from 0 to CLK_DIV-1 and wrap to 0; at wrap, digit index idx SHALL advance 0..7 and wrap from 7 to 0.
REQ-012 SHALL define the frame boundary as the cycle in which slot_cnt wraps while idx==7.
REQ-013 SHALL hold dig_sel at 8'hFF and seg_out at 8'hFF while slot_cnt < BLANK_CYC, which is the anti-ghosting blank.
REQ-014 SHALL drive dig_sel low on bit idx only while slot_cnt >= BLANK_CYC and the display is valid.
REQ-015 SHALL drive seg_out, in the same slot, to the hex-7-segment code of active nibble idx, with dp low iff active dot idx is 1.
REQ-016 SHALL use these active-low codes for hex values 0-F, bits g..a: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-017 SHALL register seg_out and dig_sel, so outputs lag internal slot_cnt/idx by exactly one cycle.
REQ-018 SHALL, when load=1, capture digits_in and dots_in into pending registers and set pend_flag on the next edge.
REQ-019 SHALL, at the frame boundary with pend_flag=1, copy pending to active, clear pend_flag, set valid=1 and pulse load_ack high for one cycle.
REQ-020 SHALL overwrite pending on repeated load before a boundary, so the latest data wins; only one load_ack SHALL result.
REQ-021 SHALL treat load in the same cycle as a frame boundary as a new pending capture; the data previously pending is applied at that boundary, and the new data at the next boundary.
REQ-022 SHALL never change active data mid-frame, so no tearing is permitted.
REQ-023 SHALL keep load_ack at 0 at a frame boundary with pend_flag=0, and the display SHALL keep its current content.

Reset
REQ-024 SHALL, while Reset_N=0, asynchronously force slot_cnt=0, idx=0, pend_flag=0, valid=0, active and pending data=0, load_ack=0, seg_out=8'hFF and dig_sel=8'hFF.
REQ-025 SHALL, after reset release, keep the display dark (dig_sel=8'hFF) until the first load_ack, while scanning continues.
REQ-026 SHALL handle reset asserted mid-frame or with load pending by discarding pending data without a load_ack; scanning restarts at idx=0, slot_cnt=0.

Verification (CLK_DIV=10, BLANK_CYC=2 unless noted)
REQ-027 SHALL cover reset then 200 idle cycles -> dig_sel=FF, seg_out=FF and load_ack never 1.
REQ-028 SHALL cover load with digits_in=32'h76543210 and dots_in=8'h01 at cycle 5 after reset -> load_ack at the first boundary (idx 7->0, cycle 80); then in slot 0, cycles 0-1 give dig_sel=FF, and cycles 2-9 give dig_sel=FE with seg_out=8'h40 (digit 0, dp lit).
REQ-029 SHALL cover a second load (32'hFFFFFFFF) in the middle of frame 2 -> frame 2 still shows 76543210; frame 3 shows all digits with seg_out=8'h8E; exactly one ack at the frame-2/3 boundary.
REQ-030 SHALL cover two loads, A then B, inside one frame -> a single load_ack, and the display shows B.
REQ-031 SHALL cover load coincident with a boundary while a prior load is pending -> the prior data is applied with an ack at that boundary, and the new data is applied with a second ack one frame later.
REQ-032 SHALL cover Reset_N pulsed low at idx=4 with load pending -> outputs go FF immediately, no ack follows, and the display stays dark until a new load completes.
